// File: rtl/pixel_stream_block.sv
// pixel_stream_block
// Captures pixels from a VSYNC/HSYNC framed stream. A small FSM tracks frame
// and line phase. Registered outputs carry the last captured pixel, a blanking
// indicator, a post-frame freeze flag and a one-cycle frame-done pulse.
// After reset the block waits for VSYNC low before it captures anything, so a
// frame that is already running when reset is released is never taken.

module pixel_stream_block (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        HSYNC,
    input  logic        VSYNC,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        pause_r,
    output logic        freeze_r,
    output logic        done_out
);

    typedef enum logic [2:0] {
        ST_ARM   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_BLANK = 3'd2,
        ST_LINE  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Registered state
    state_t      state_q;
    logic        h_q;
    logic        v_q;
    logic [15:0] data_q;
    logic        pause_q;
    logic        freeze_q;
    logic        done_q;
    logic [15:0] line_cnt_q;
    logic [15:0] pix_cnt_q;

    // Next-state and decode signals
    state_t      state_d;
    logic [15:0] data_d;
    logic        pause_d;
    logic        freeze_d;
    logic        done_d;
    logic [15:0] line_cnt_d;
    logic [15:0] pix_cnt_d;

    logic        vs_rise_s;
    logic        vs_fall_s;
    logic        hs_rise_s;
    logic        in_frame_s;
    logic        frame_start_s;
    logic        frame_end_s;
    logic        capture_s;

    // Saturating increment shared by the line and pixel counters
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        logic [15:0] result;
        if (value == CNT_MAX) begin
            result = CNT_MAX;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    // Edge detection and qualifiers derived from the current sample and state
    always_comb begin
        vs_rise_s     = VSYNC & ~v_q;
        vs_fall_s     = ~VSYNC & v_q;
        hs_rise_s     = HSYNC & ~h_q;
        in_frame_s    = (state_q == ST_BLANK) || (state_q == ST_LINE);
        frame_start_s = vs_rise_s && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        frame_end_s   = in_frame_s && vs_fall_s;
        // VSYNC must be high, so a VSYNC fall with HSYNC high never captures.
        capture_s     = VSYNC && HSYNC && (state_q != ST_ARM);
    end

    // FSM next-state: frame start picks BLANK or LINE from the HSYNC level
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARM: begin
                if (!VSYNC) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (vs_rise_s) begin
                    state_d = HSYNC ? ST_LINE : ST_BLANK;
                end else begin
                    state_d = state_q;
                end
            end
            ST_BLANK: begin
                if (vs_fall_s) begin
                    state_d = ST_DONE;
                end else if (VSYNC && HSYNC) begin
                    state_d = ST_LINE;
                end else begin
                    state_d = ST_BLANK;
                end
            end
            ST_LINE: begin
                // A VSYNC fall mid-line simply ends the frame.
                if (vs_fall_s) begin
                    state_d = ST_DONE;
                end else if (VSYNC && !HSYNC) begin
                    state_d = ST_BLANK;
                end else begin
                    state_d = ST_LINE;
                end
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    // Per-frame line and pixel counters, restarted on each frame start
    always_comb begin
        line_cnt_d = line_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        if (frame_start_s) begin
            // A frame that opens with HSYNC high starts its first line immediately.
            line_cnt_d = HSYNC ? 16'd1 : 16'd0;
            pix_cnt_d  = capture_s ? 16'd1 : 16'd0;
        end else if (in_frame_s && VSYNC) begin
            if (hs_rise_s) begin
                line_cnt_d = sat_inc(line_cnt_q);
            end else begin
                line_cnt_d = line_cnt_q;
            end
            if (capture_s) begin
                pix_cnt_d = sat_inc(pix_cnt_q);
            end else begin
                pix_cnt_d = pix_cnt_q;
            end
        end else begin
            line_cnt_d = line_cnt_q;
            pix_cnt_d  = pix_cnt_q;
        end
    end

    // Output next-values: capture, blanking, freeze and done pulse
    always_comb begin
        if (capture_s) begin
            data_d = data_in;
        end else begin
            data_d = data_q;
        end
        pause_d  = VSYNC && !HSYNC && (state_q != ST_ARM);
        freeze_d = (state_d == ST_DONE);
        // Frames that captured nothing still end, but without a pulse.
        done_d   = frame_end_s && (pix_cnt_q != 16'd0);
    end

    // Single register bank for FSM state, sync history, counters and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ARM;
            h_q        <= 1'b0;
            v_q        <= 1'b0;
            data_q     <= 16'h0000;
            pause_q    <= 1'b0;
            freeze_q   <= 1'b0;
            done_q     <= 1'b0;
            line_cnt_q <= 16'd0;
            pix_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            h_q        <= HSYNC;
            v_q        <= VSYNC;
            data_q     <= data_d;
            pause_q    <= pause_d;
            freeze_q   <= freeze_d;
            done_q     <= done_d;
            line_cnt_q <= line_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
        end
    end

    assign data_out = data_q;
    assign pause_r  = pause_q;
    assign freeze_r = freeze_q;
    assign done_out = done_q;

endmodule

// File: tb/tb_pixel_stream_block.sv
// Directed bench for pixel_stream_block: hand-computed expectations checked
// with immediate assertions, one linear stimulus sequence.

module tb_pixel_stream_block;

    logic        clk;
    logic        rst_n;
    logic        HSYNC;
    logic        VSYNC;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        pause_r;
    logic        freeze_r;
    logic        done_out;

    int vectors;
    int miscompares;

    pixel_stream_block dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .HSYNC    (HSYNC),
        .VSYNC    (VSYNC),
        .data_in  (data_in),
        .data_out (data_out),
        .pause_r  (pause_r),
        .freeze_r (freeze_r),
        .done_out (done_out)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus sequence
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b1;
        VSYNC   = 1'b0;
        HSYNC   = 1'b0;
        data_in = 16'h0000;

        // Asynchronous reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_data",   data_out,         16'h0000);
        check("rst_pause",  16'(pause_r),     16'd0);
        check("rst_freeze", 16'(freeze_r),    16'd0);
        check("rst_done",   16'(done_out),    16'd0);
        check("rst_lines",  dut.line_cnt_q,   16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Frame starts in blanking
        VSYNC = 1'b1;
        HSYNC = 1'b0;
        tick();
        check("blank_pause1", 16'(pause_r), 16'd1);
        tick();
        check("blank_pause2", 16'(pause_r), 16'd1);
        check("blank_data",   data_out,     16'h0000);
        check("blank_freeze", 16'(freeze_r), 16'd0);

        // First line, three pixels
        HSYNC = 1'b1;
        data_in = 16'h1111;
        tick();
        check("l1_px0", data_out, 16'h1111);
        check("l1_pause", 16'(pause_r), 16'd0);
        data_in = 16'hAAAA;
        tick();
        check("l1_px1", data_out, 16'hAAAA);
        data_in = 16'hFFFF;
        tick();
        check("l1_px2", data_out, 16'hFFFF);
        check("l1_pause2", 16'(pause_r), 16'd0);

        // Inter-line blanking then a five-pixel line
        HSYNC = 1'b0;
        data_in = 16'h3333;
        tick();
        tick();
        check("gap_pause", 16'(pause_r), 16'd1);
        check("gap_hold",  data_out,     16'hFFFF);
        HSYNC = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = 16'h0100 + 16'(i);
            tick();
            check("l2_px", data_out, 16'h0100 + 16'(i));
        end
        HSYNC = 1'b0;
        tick();
        check("l2_end_pause", 16'(pause_r),  16'd1);
        check("l2_end_done",  16'(done_out), 16'd0);

        // Frame end: one-cycle done pulse, freeze held
        VSYNC = 1'b0;
        tick();
        check("end_done",   16'(done_out), 16'd1);
        check("end_freeze", 16'(freeze_r), 16'd1);
        check("end_pause",  16'(pause_r),  16'd0);
        check("end_data",   data_out,      16'h0104);
        tick();
        check("end_done_off", 16'(done_out), 16'd0);
        check("end_freeze2",  16'(freeze_r), 16'd1);
        check("end_data2",    data_out,      16'h0104);
        check("end_lines",    dut.line_cnt_q, 16'd2);

        // HSYNC activity with VSYNC low is ignored
        data_in = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            HSYNC = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            check("vlow_data",  data_out,      16'h0104);
            check("vlow_pause", 16'(pause_r),  16'd0);
            check("vlow_done",  16'(done_out), 16'd0);
        end

        // Frame opening mid-line, then VSYNC falls with HSYNC high
        VSYNC = 1'b1;
        HSYNC = 1'b1;
        data_in = 16'h1234;
        tick();
        check("f2_freeze_clr", 16'(freeze_r), 16'd0);
        check("f2_px0",        data_out,      16'h1234);
        data_in = 16'h2345;
        tick();
        check("f2_px1", data_out, 16'h2345);
        VSYNC = 1'b0;
        data_in = 16'hDEAD;
        tick();
        check("f2_nocap",  data_out,      16'h2345);
        check("f2_done",   16'(done_out), 16'd1);
        check("f2_freeze", 16'(freeze_r), 16'd1);
        HSYNC = 1'b0;
        tick();
        check("f2_done_off", 16'(done_out), 16'd0);
        check("f2_hold",     data_out,      16'h2345);

        // Zero-pixel frame ends without a pulse
        VSYNC = 1'b1;
        tick();
        check("f3_freeze_clr", 16'(freeze_r), 16'd0);
        check("f3_pause",      16'(pause_r),  16'd1);
        VSYNC = 1'b0;
        tick();
        check("f3_nodone", 16'(done_out), 16'd0);
        check("f3_freeze", 16'(freeze_r), 16'd1);

        // Reset mid-frame, release with VSYNC already high
        VSYNC = 1'b1;
        tick();
        HSYNC = 1'b1;
        data_in = 16'h7777;
        tick();
        check("f4_px", data_out, 16'h7777);
        #2 rst_n = 1'b0;
        #1;
        check("abort_data",   data_out,      16'h0000);
        check("abort_freeze", 16'(freeze_r), 16'd0);
        tick();
        rst_n = 1'b1;
        data_in = 16'h8888;
        tick();
        check("arm_nocap1", data_out,      16'h0000);
        check("arm_done",   16'(done_out), 16'd0);
        HSYNC = 1'b0;
        tick();
        check("arm_pause", 16'(pause_r), 16'd0);
        HSYNC = 1'b1;
        tick();
        check("arm_nocap2", data_out, 16'h0000);
        VSYNC = 1'b0;
        HSYNC = 1'b0;
        tick();
        check("arm_exit_done",   16'(done_out), 16'd0);
        check("arm_exit_freeze", 16'(freeze_r), 16'd0);
        VSYNC = 1'b1;
        HSYNC = 1'b1;
        data_in = 16'h9999;
        tick();
        check("rearm_px", data_out, 16'h9999);
        VSYNC = 1'b0;
        HSYNC = 1'b0;
        tick();
        check("rearm_done", 16'(done_out), 16'd1);
        check("rearm_freeze", 16'(freeze_r), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_stream_block.md
PIXEL_STREAM_BLOCK -- requirements
Module: pixel_stream_block

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset; reset is asynchronous and active-low.
REQ-003 HSYNC  input  1  line-valid strobe; high = pixel present on data_in; synchronous to clk.
REQ-004 VSYNC  input  1  frame-valid strobe; high = frame in progress; synchronous to clk.
REQ-005 data_in  input  16  pixel word, sampled only when HSYNC and VSYNC both high.
REQ-006 data_out  output  16  registered captured pixel.
REQ-007 pause_r  output  1  registered; high during inter-line blanking of an active frame.
REQ-008 freeze_r  output  1  registered; high from frame completion until next frame start.
REQ-009 done_out  output  1  registered one-cycle pulse at frame completion.

Function
REQ-010 The block SHALL register HSYNC and VSYNC once (h_q, v_q) for edge detection; VSYNC rise = VSYNC & ~v_q, VSYNC fall = ~VSYNC & v_q.
REQ-011 The FSM SHALL have states ARM, IDLE, BLANK, LINE, DONE.
REQ-012 ARM: entered from reset; leaves to IDLE when VSYNC sampled low, so a frame already in progress at reset release is never captured.
REQ-013 IDLE -> BLANK on VSYNC rise with HSYNC low; IDLE -> LINE on VSYNC rise with HSYNC high.
REQ-014 BLANK -> LINE on HSYNC high with VSYNC high; LINE -> BLANK on HSYNC low with VSYNC high.
REQ-015 BLANK or LINE -> DONE on VSYNC fall, including mid-line; the partial line is terminated without error.
REQ-016 DONE -> BLANK or LINE on next VSYNC rise, using the same HSYNC rule as REQ-013; DONE persists otherwise.
REQ-017 Capture: on any edge where VSYNC and HSYNC are both high, outside ARM, data_out SHALL load data_in; latency 1 cycle. Otherwise data_out holds its value.
REQ-018 pause_r SHALL be 1 on the cycle after an edge where VSYNC=1, HSYNC=0 and the state is not ARM; otherwise 0.
REQ-019 freeze_r SHALL be 1 while in DONE; it clears on the edge of the VSYNC rise that leaves DONE.
REQ-020 done_out SHALL pulse high for exactly one cycle on the edge that enters DONE, but only if at least one pixel was captured in that frame; zero-pixel frames still enter DONE without a pulse.
REQ-021 An internal 16-bit line counter SHALL increment on each HSYNC rise within a frame and saturate at 0xFFFF. An internal 16-bit pixel counter SHALL count captured pixels per frame and saturate at 0xFFFF. Both SHALL clear on frame start.
REQ-022 HSYNC activity while VSYNC is low SHALL be ignored: no capture, no pause, no count.
REQ-023 Simultaneous VSYNC fall and HSYNC high SHALL produce no capture; the DONE transition takes priority.

Reset
REQ-024 On rst_n low, asynchronously: data_out=16'h0000, pause_r=0, freeze_r=0, done_out=0, counters=0, h_q=v_q=0, state=ARM.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no done_out pulse; after release, capture resumes only after VSYNC has been seen low.

Verification
REQ-026 Reset, then VSYNC=1 with HSYNC=0 for 2 cycles -> pause_r=1, data_out=0000, freeze_r=0.
REQ-027 HSYNC=1 with data_in 1111, AAAA, FFFF on consecutive cycles -> data_out 1111, AAAA, FFFF one cycle later each; pause_r=0.
REQ-028 HSYNC low 2 cycles, high 5 cycles, then low; VSYNC falls -> done_out high exactly 1 cycle, freeze_r=1 held, data_out frozen at last captured value, line count=2.
REQ-029 HSYNC toggled while VSYNC=0 with data_in=5555 -> data_out unchanged, pause_r=0, no done_out.
REQ-030 Release reset with VSYNC already 1, then HSYNC pulses -> no capture until VSYNC goes 0 then 1.
REQ-031 VSYNC falls while HSYNC=1 -> no capture on that edge; done_out pulses once; next VSYNC rise clears freeze_r.
